// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner with per-slot PWM brightness, a guard step per slot,
// and double-buffered display data that only swaps at the frame boundary.
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 125,
  parameter int DUTY_BITS = 3
) (
  input  logic                   system1000,
  input  logic                   system1000_rst,
  input  logic                   load,
  input  logic [4*DIGITS-1:0]    value,
  input  logic [DIGITS-1:0]      dp,
  input  logic [DIGITS-1:0]      blank,
  input  logic [DUTY_BITS-1:0]   bright,
  output logic [DIGITS-1:0]      an,
  output logic [7:0]             seg,
  output logic                   frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]        PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [DUTY_BITS-1:0] STEP_MAX  = '1;
  localparam logic [DW-1:0]        DIGIT_MAX = DW'(DIGITS - 1);

  logic [PW-1:0]        pre_q, pre_d;
  logic [DUTY_BITS-1:0] step_q, step_d;
  logic [DW-1:0]        digit_q, digit_d;

  logic [4*DIGITS-1:0]  sh_value_q, sh_value_d;
  logic [DIGITS-1:0]    sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]    sh_blank_q, sh_blank_d;
  logic [DUTY_BITS-1:0] sh_bright_q, sh_bright_d;

  logic [4*DIGITS-1:0]  disp_value_q, disp_value_d;
  logic [DIGITS-1:0]    disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]    disp_blank_q, disp_blank_d;
  logic [DUTY_BITS-1:0] disp_bright_q, disp_bright_d;

  logic [DIGITS-1:0]    an_q, an_d;
  logic [7:0]           seg_q, seg_d;
  logic                 frame_done_q, frame_done_d;

  logic                 pre_wrap, step_wrap, frame_end, lit;
  logic [3:0]           nib [DIGITS];

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  always_comb begin
    pre_wrap  = (pre_q == PRE_MAX);
    step_wrap = (step_q == STEP_MAX);
    frame_end = pre_wrap && step_wrap && (digit_q == DIGIT_MAX);

    pre_d   = pre_wrap ? '0 : pre_q + 1'b1;
    step_d  = step_q;
    digit_d = digit_q;
    if (pre_wrap) begin
      step_d = step_wrap ? '0 : step_q + 1'b1;
      if (step_wrap) begin
        digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + 1'b1;
      end
    end
  end

  // The display set takes the shadow's next value so a load on the boundary lands immediately.
  always_comb begin
    sh_value_d  = load ? value  : sh_value_q;
    sh_dp_d     = load ? dp     : sh_dp_q;
    sh_blank_d  = load ? blank  : sh_blank_q;
    sh_bright_d = load ? bright : sh_bright_q;

    disp_value_d  = frame_end ? sh_value_d  : disp_value_q;
    disp_dp_d     = frame_end ? sh_dp_d     : disp_dp_q;
    disp_blank_d  = frame_end ? sh_blank_d  : disp_blank_q;
    disp_bright_d = frame_end ? sh_bright_d : disp_bright_q;
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi]  = disp_value_q[4*gi +: 4];
      assign an_d[gi] = ~(lit && (digit_q == DW'(gi)));
    end
  endgenerate

  // Step 0 is the anti-ghosting guard; steps 1..bright light the digit.
  always_comb begin
    lit = (step_q != '0) && (step_q <= disp_bright_q) && !disp_blank_q[digit_q];
    seg_d = 8'hFF;
    if (lit) begin
      seg_d = {~disp_dp_q[digit_q], hex_glyph(nib[digit_q])};
    end
    frame_done_d = frame_end;
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      pre_q         <= '0;
      step_q        <= '0;
      digit_q       <= '0;
      sh_value_q    <= '0;
      sh_dp_q       <= '0;
      sh_blank_q    <= '1;
      sh_bright_q   <= '0;
      disp_value_q  <= '0;
      disp_dp_q     <= '0;
      disp_blank_q  <= '1;
      disp_bright_q <= '0;
      an_q          <= '1;
      seg_q         <= 8'hFF;
      frame_done_q  <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      step_q        <= step_d;
      digit_q       <= digit_d;
      sh_value_q    <= sh_value_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      sh_bright_q   <= sh_bright_d;
      disp_value_q  <= disp_value_d;
      disp_dp_q     <= disp_dp_d;
      disp_blank_q  <= disp_blank_d;
      disp_bright_q <= disp_bright_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, prescale 2, 2 duty bits: 8-cycle slot, 32-cycle frame).
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int PS    = 2;
  localparam int STEPS = 4;
  localparam int SLOT  = PS * STEPS;
  localparam int FRAME = SLOT * ND;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic [1:0]  bright = '0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_fd;

  seg7_scan_driver #(.DIGITS(ND), .PRESCALE(PS), .DUTY_BITS(2)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .load           (load),
    .value          (value),
    .dp             (dp),
    .blank          (blank),
    .bright         (bright),
    .an             (an),
    .seg            (seg),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  // Model: position in the scan derived arithmetically from cycles since reset release.
  initial begin
    int n, step, dig;
    logic [15:0] s_val, d_val;
    logic [3:0]  s_dp, d_dp, s_bl, d_bl;
    logic [1:0]  s_br, d_br;
    logic        on;
    n = 0; s_val = '0; d_val = '0; s_dp = '0; d_dp = '0;
    s_bl = '1; d_bl = '1; s_br = '0; d_br = '0;
    exp_an = 4'hF; exp_seg = 8'hFF; exp_fd = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        n = 0; s_val = '0; d_val = '0; s_dp = '0; d_dp = '0;
        s_bl = '1; d_bl = '1; s_br = '0; d_br = '0;
        exp_an = 4'hF; exp_seg = 8'hFF; exp_fd = 1'b0;
      end else begin
        step = (n / PS) % STEPS;
        dig  = (n / SLOT) % ND;
        on   = (step != 0) && (step <= int'(d_br)) && !d_bl[dig];
        exp_an  = on ? ~(4'b0001 << dig) : 4'hF;
        exp_seg = on ? {~d_dp[dig], GLYPH[d_val[dig*4 +: 4]]} : 8'hFF;
        exp_fd  = (n % FRAME) == FRAME - 1;
        if (load) begin
          s_val = value; s_dp = dp; s_bl = blank; s_br = bright;
        end
        if ((n % FRAME) == FRAME - 1) begin
          d_val = s_val; d_dp = s_dp; d_bl = s_bl; d_br = s_br;
        end
        n++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL model_cmp t=%0t an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                 $time, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                         input logic [1:0] br);
    @(negedge clk);
    value = v; dp = d; blank = b; bright = br; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < 3 * FRAME);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_done never seen within %0d cycles", name, k);
    end
  endtask

  // Samples the 32 cycles following a frame_done pulse and checks glyphs, order and on-time.
  task automatic observe(input string name, input logic [7:0] g0, input logic [7:0] g1,
                         input logic [7:0] g2, input logic [7:0] g3,
                         input int c0, input int c1, input int c2, input int c3);
    int cnt [4];
    int c [4];
    logic [7:0] g [4];
    int k;
    g = '{g0, g1, g2, g3};
    c = '{c0, c1, c2, c3};
    cnt = '{0, 0, 0, 0};
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (an === 4'hF) begin
        if (seg !== 8'hFF) begin
          errors++;
          $display("FAIL %s dark_seg cycle %0d seg=%b want 11111111", name, i, seg);
        end
      end else begin
        k = 0;
        for (int j = 3; j >= 0; j--) if (an[j] == 1'b0) k = j;
        cnt[k]++;
        if ($countones(~an) != 1 || k != i / SLOT || (i % SLOT) < PS || seg !== g[k]) begin
          errors++;
          $display("FAIL %s lit cycle %0d an=%b seg=%b want digit %0d glyph %b, not in guard step",
                   name, i, an, seg, i / SLOT, g[i / SLOT]);
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (cnt[j] != c[j]) begin
        errors++;
        $display("FAIL %s on_count digit %0d got %0d want %0d", name, j, cnt[j], c[j]);
      end
    end
  endtask

  initial begin
    int fd_cnt, lit_cnt, fd_pos, k;

    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state an=%b seg=%b fd=%b want 1111 11111111 0", an, seg, frame_done);
    end
    rst = 1'b0;

    fd_cnt = 0; lit_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (an !== 4'hF || seg !== 8'hFF) lit_cnt++;
    end
    checks++;
    if (fd_cnt != 2 || lit_cnt != 0) begin
      errors++;
      $display("FAIL idle fd_pulses=%0d lit_cycles=%0d want 2 and 0", fd_cnt, lit_cnt);
    end

    do_load(16'h8F10, 4'b0001, 4'b0000, 2'd3);
    wait_fd("b3_wait");
    observe("bright3", 8'b01000000, 8'b11111001, 8'b10001110, 8'b10000000, 6, 6, 6, 6);

    do_load(16'h8F10, 4'b0001, 4'b0000, 2'd1);
    wait_fd("b1_wait");
    observe("bright1", 8'b01000000, 8'b11111001, 8'b10001110, 8'b10000000, 2, 2, 2, 2);

    do_load(16'h8F10, 4'b0001, 4'b0000, 2'd0);
    wait_fd("b0_wait");
    observe("bright0", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 0);

    do_load(16'h8F10, 4'b0000, 4'b0000, 2'd3);
    wait_fd("mid_setup");
    repeat (12) @(negedge clk);
    do_load(16'h1234, 4'b0000, 4'b0000, 2'd3);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (an !== 4'b0111 && k < FRAME);
    checks++;
    if (an !== 4'b0111 || seg !== 8'b10000000) begin
      errors++;
      $display("FAIL no_tear an=%b seg=%b want 0111 10000000", an, seg);
    end
    wait_fd("mid_wait");
    observe("mid_load", 8'b10011001, 8'b10110000, 8'b10100100, 8'b11111001, 6, 6, 6, 6);

    repeat (FRAME - 1) @(negedge clk);
    value = 16'hABCD; dp = 4'b1010; blank = 4'b0000; bright = 2'd3; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL boundary_fd got %b want 1", frame_done);
    end
    observe("boundary_load", 8'b10100001, 8'b01000110, 8'b10000011, 8'b00001000, 6, 6, 6, 6);

    repeat (20) @(negedge clk);
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL pre_reset_lit an=%b want 1011", an);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset an=%b seg=%b fd=%b want 1111 11111111 0", an, seg, frame_done);
    end
    value = 16'h1111; dp = 4'b1111; blank = 4'b0000; bright = 2'd3; load = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b0;
    rst = 1'b0;
    fd_pos = 0; lit_cnt = 0;
    for (int i = 1; i <= FRAME + 8; i++) begin
      @(negedge clk);
      if (frame_done && fd_pos == 0) fd_pos = i;
      if (an !== 4'hF || seg !== 8'hFF) lit_cnt++;
    end
    checks++;
    if (fd_pos != FRAME || lit_cnt != 0) begin
      errors++;
      $display("FAIL restart fd_at=%0d lit_cycles=%0d want %0d and 0", fd_pos, lit_cnt, FRAME);
    end

    do_load(16'h8F10, 4'b0001, 4'b0100, 2'd3);
    wait_fd("blank_wait");
    observe("blank2", 8'b01000000, 8'b11111001, 8'hFF, 8'b10000000, 6, 6, 0, 6);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
